// File: rtl/freq_meas_ctrl_pkg.sv
// Shared types and constants for the frequency measurement controller.
// State encoding, BCD limits and the BCD-to-binary helper.
package freq_meas_ctrl_pkg;

  localparam int DIGIT_W = 4;
  localparam int HUND_W  = 2;
  localparam int BCD_W   = 2 * DIGIT_W + HUND_W;

  localparam logic [BCD_W-1:0] BCD_MAX = 10'h399;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GATE  = 2'd1,
    S_LATCH = 2'd2
  } state_t;

  function automatic logic [BCD_W-1:0] bcd_to_bin(
    input logic [BCD_W-1:0] b
  );
    logic [BCD_W-1:0] ones;
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] hund;
    ones = BCD_W'(b[DIGIT_W-1:0]);
    tens = BCD_W'(b[2*DIGIT_W-1:DIGIT_W]);
    hund = BCD_W'(b[BCD_W-1:2*DIGIT_W]);
    return (hund * 10'd100) + (tens * 10'd10) + ones;
  endfunction

endpackage

// File: rtl/freq_meas_ctrl_bcd3_counter.sv
// Three-digit BCD event counter, saturating at 399.
// Clear has priority over increment; overflow is sticky until clear.
module bcd3_counter
  import freq_meas_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [BCD_W-1:0] count,
  output logic             ovf
);

  logic [DIGIT_W-1:0] r_ones;
  logic [DIGIT_W-1:0] r_tens;
  logic [HUND_W-1:0]  r_hund;
  logic               r_ovf;
  logic               w_sat;

  assign count = {r_hund, r_tens, r_ones};
  assign ovf   = r_ovf;
  assign w_sat = (count == BCD_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ones <= '0;
      r_tens <= '0;
      r_hund <= '0;
      r_ovf  <= 1'b0;
    end else if (clear) begin
      r_ones <= '0;
      r_tens <= '0;
      r_hund <= '0;
      r_ovf  <= 1'b0;
    end else if (inc) begin
      if (w_sat) begin
        r_ovf <= 1'b1;
      end else if (r_ones == 4'd9) begin
        r_ones <= '0;
        if (r_tens == 4'd9) begin
          r_tens <= '0;
          r_hund <= r_hund + 2'd1;
        end else begin
          r_tens <= r_tens + 4'd1;
        end
      end else begin
        r_ones <= r_ones + 4'd1;
      end
    end
  end

endmodule

// File: rtl/freq_meas_ctrl.sv
// Gated frequency counter: counts sig_in rising edges over a fixed
// window of clk cycles and latches the result in BCD and binary.
module freq_meas_ctrl
  import freq_meas_ctrl_pkg::*;
#(
  parameter int GATE_CYCLES = 50_000_000,
  parameter int LOW_THR     = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             start,
  input  logic             cont,
  output logic [BCD_W-1:0] bcd_out,
  output logic [BCD_W-1:0] hz_out,
  output logic             valid,
  output logic             busy,
  output logic             ovf,
  output logic             led0
);

  localparam int GW =
    (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0] GATE_LAST =
    GW'(GATE_CYCLES - 1);
  localparam logic [BCD_W-1:0] THR =
    BCD_W'(LOW_THR);

  state_t r_state;
  state_t w_next;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_hist;
  logic             w_rise;
  logic [GW-1:0]    r_gate_cnt;
  logic             w_gate_done;
  logic             w_clear;
  logic             w_inc;
  logic [BCD_W-1:0] w_count;
  logic [BCD_W-1:0] w_hz;
  logic             w_ovf;

  logic [BCD_W-1:0] r_bcd;
  logic [BCD_W-1:0] r_hz;
  logic             r_valid;
  logic             r_ovf;
  logic             r_led;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= 1'b0;
    end else begin
      r_sync1 <= sig_in;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  assign w_rise      = r_sync2 & ~r_hist;
  assign w_gate_done = (r_gate_cnt == GATE_LAST);

  always_comb begin
    w_next  = r_state;
    w_clear = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start || cont) begin
          w_next  = S_GATE;
          w_clear = 1'b1;
        end
      end
      S_GATE: begin
        if (w_gate_done) w_next = S_LATCH;
      end
      S_LATCH: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gate_cnt <= '0;
    end else if (w_clear) begin
      r_gate_cnt <= '0;
    end else if (r_state == S_GATE && !w_gate_done) begin
      r_gate_cnt <= r_gate_cnt + GW'(1);
    end
  end

  // The last gate cycle's edge lands in the counter on the LATCH edge.
  assign w_inc = (r_state == S_GATE) & w_rise;

  bcd3_counter u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (w_clear),
    .inc   (w_inc),
    .count (w_count),
    .ovf   (w_ovf)
  );

  assign w_hz = bcd_to_bin(w_count);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcd   <= '0;
      r_hz    <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      r_led   <= 1'b0;
    end else begin
      r_valid <= (r_state == S_LATCH);
      if (r_state == S_LATCH) begin
        r_bcd <= w_count;
        r_hz  <= w_hz;
        r_ovf <= w_ovf;
        r_led <= (w_hz <= THR) && !w_ovf;
      end
    end
  end

  assign bcd_out = r_bcd;
  assign hz_out  = r_hz;
  assign valid   = r_valid;
  assign ovf     = r_ovf;
  assign led0    = r_led;
  assign busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Scoreboard bench for freq_meas_ctrl: planned sig_in streams are
// reduced to expected results up front, a monitor checks each valid.
module tb_freq_meas_ctrl;

  localparam int G   = 1000;
  localparam int THR = 40;
  localparam int SAT = 399;

  typedef struct {
    int cyc;
    int bcd;
    int hz;
    int ovf;
    int led;
  } exp_t;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       sig_in = 1'b0;
  logic       start  = 1'b0;
  logic       cont   = 1'b0;
  logic [9:0] bcd_out;
  logic [9:0] hz_out;
  logic       valid;
  logic       busy;
  logic       ovf;
  logic       led0;

  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  bit   sigv[];

  freq_meas_ctrl #(
    .GATE_CYCLES (G),
    .LOW_THR     (THR)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sig_in  (sig_in),
    .start   (start),
    .cont    (cont),
    .bcd_out (bcd_out),
    .hz_out  (hz_out),
    .valid   (valid),
    .busy    (busy),
    .ovf     (ovf),
    .led0    (led0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d (cyc %0d)", nm, got, want, cyc);
    end
  endtask

  // Expected result of a gate that saw n_raw qualifying rising edges.
  function automatic exp_t model(input int n_raw, input int e_cyc);
    exp_t e;
    int   n;
    n     = (n_raw > SAT) ? SAT : n_raw;
    e.cyc = e_cyc;
    e.hz  = n;
    e.bcd = (n / 100) * 256 + ((n / 10) % 10) * 16 + (n % 10);
    e.ovf = (n_raw > SAT) ? 1 : 0;
    e.led = (n <= THR && n_raw <= SAT) ? 1 : 0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && valid) begin
      if (q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("valid_cycle", cyc, e.cyc);
        check("bcd_out", int'(bcd_out), e.bcd);
        check("hz_out", int'(hz_out), e.hz);
        check("ovf", int'(ovf), e.ovf);
        check("led0", int'(led0), e.led);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_clear(input int len);
    sigv = new[len];
    foreach (sigv[i]) sigv[i] = 1'b0;
  endtask

  task automatic fill_periodic(input int first, input int period,
                               input int n);
    for (int i = 0; i < n; i++) sigv[first + i * period] = 1'b1;
  endtask

  task automatic fill_random(input int dens);
    foreach (sigv[i]) sigv[i] = ($urandom_range(0, dens - 1) == 0);
  endtask

  // A rise driven at offset o relative to the start drive cycle counts
  // for measurement k when it lands in [k*(G+2)-1, k*(G+2)+G-2],
  // i.e. two synchronizer cycles ahead of the gate window.
  task automatic run(input int nmeas, input bit use_cont,
                     input int spur);
    int c;
    int n;
    int lo;
    int hi;
    int len;
    len = use_cont ? nmeas * (G + 2) : G + 2;
    c   = cyc;
    for (int k = 0; k < nmeas; k++) begin
      lo = k * (G + 2) - 1;
      hi = k * (G + 2) + G - 2;
      n  = 0;
      for (int o = 0; o < len; o++) begin
        if (o >= lo && o <= hi && sigv[o] &&
            (o == 0 || !sigv[o - 1]))
          n++;
      end
      q.push_back(model(n, c + G + 2 + k * (G + 2)));
    end
    for (int o = 0; o < len; o++) begin
      sig_in = sigv[o];
      start  = (o == 0) || (o == spur);
      cont   = use_cont && (o < (nmeas - 1) * (G + 2) + 10);
      tick();
    end
    sig_in = 1'b0;
    start  = 1'b0;
    cont   = 1'b0;
    repeat (6) tick();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_bcd"}, int'(bcd_out), 0);
    check({tag, "_hz"}, int'(hz_out), 0);
    check({tag, "_valid"}, int'(valid), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_ovf"}, int'(ovf), 0);
    check({tag, "_led0"}, int'(led0), 0);
  endtask

  initial begin
    repeat (3) tick();
    check_zero("reset");
    rst_n = 1'b1;
    repeat (5) tick();
    check("idle_no_start_busy", int'(busy), 0);

    fill_clear(G + 2);
    fill_periodic(5, 4, 25);
    run(1, 1'b0, 50);

    fill_clear(G + 2);
    fill_periodic(5, 2, 50);
    run(1, 1'b0, -1);

    fill_clear(G + 2);
    fill_periodic(0, 2, 450);
    run(1, 1'b0, -1);

    fill_clear(G + 2);
    fill_periodic(10, 2, 39);
    sigv[G - 2] = 1'b1;
    sigv[G]     = 1'b1;
    run(1, 1'b0, -1);

    fill_clear(G + 2);
    fill_periodic(10, 2, 40);
    sigv[G - 2] = 1'b1;
    run(1, 1'b0, -1);

    fill_clear(G + 2);
    fill_periodic(10, 2, 40);
    sigv[G - 1] = 1'b1;
    run(1, 1'b0, -1);

    fill_clear(G + 2);
    fill_periodic(5, 4, 20);
    sig_in = 1'b0;
    start  = 1'b1;
    for (int o = 0; o < 90; o++) begin
      sig_in = sigv[o];
      tick();
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check_zero("mid_gate_reset");
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < G + 20; i++) begin
      sig_in = ($urandom_range(0, 1) == 1);
      tick();
    end
    sig_in = 1'b0;
    repeat (4) tick();
    check("post_reset_busy", int'(busy), 0);
    check("post_reset_hz", int'(hz_out), 0);

    fill_clear(3 * (G + 2));
    fill_random(4);
    run(3, 1'b1, 50);

    for (int t = 0; t < 4; t++) begin
      fill_clear(G + 2);
      fill_random((t % 2 == 0) ? 2 : 30);
      run(1, 1'b0, $urandom_range(2, G - 2));
    end

    for (int i = 0; i < 5000 && q.size() != 0; i++) tick();
    check("scoreboard_drain", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
